// File: rtl/spi_reg_bridge_if.sv
// Pin-side SPI signals and register-file strobe port of the SPI register bridge.
// The slave view belongs to the bridge; the master view drives it (SPI master plus register file).
interface spi_reg_bridge_if;
  logic       sclk;
  logic       cs_n;
  logic       mosi;
  logic       miso;
  logic       read;
  logic       write;
  logic [5:0] addr;
  logic [7:0] data_write;
  logic [7:0] data_read;

  modport slave (
    input  sclk, cs_n, mosi, data_read,
    output miso, read, write, addr, data_write
  );

  modport master (
    output sclk, cs_n, mosi, data_read,
    input  miso, read, write, addr, data_write
  );
endinterface

// File: rtl/spi_reg_bridge.sv
// SPI mode-0 slave that converts 2-byte frames into single-clk read/write strobes.
// All SPI pins are oversampled in the clk domain; sclk never clocks any flop.
module spi_reg_bridge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  spi_reg_bridge_if.slave bus
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] CMD     = 3'd1;
  localparam logic [2:0] RD_REQ  = 3'd2;
  localparam logic [2:0] RD_LOAD = 3'd3;
  localparam logic [2:0] DATA    = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;

  logic [SYNC_STAGES-1:0] sclk_sync_r;
  logic [SYNC_STAGES-1:0] cs_sync_r;
  logic [SYNC_STAGES-1:0] mosi_sync_r;

  logic [2:0] state_r;
  logic [2:0] bit_cnt_r;
  logic [7:0] rx_r;
  logic [7:0] tx_r;
  logic       rw_r;
  logic [5:0] addr_r;
  logic [7:0] data_write_r;
  logic       read_r;
  logic       write_r;
  logic       miso_r;

  logic sclk_rise_s;
  logic sclk_fall_s;
  logic cs_fall_s;
  logic cs_high_s;
  logic mosi_s;

  // Input synchronizer chains; the oldest two stages feed the edge detectors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_r <= '0;
      cs_sync_r   <= '0;
      mosi_sync_r <= '0;
    end else begin
      sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], bus.sclk};
      cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], bus.cs_n};
      mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], bus.mosi};
    end
  end

  assign sclk_rise_s = sclk_sync_r[SYNC_STAGES-2] & ~sclk_sync_r[SYNC_STAGES-1];
  assign sclk_fall_s = ~sclk_sync_r[SYNC_STAGES-2] & sclk_sync_r[SYNC_STAGES-1];
  // Sync regs reset low, so a frame needs a real cs_n high->low after reset.
  assign cs_fall_s   = ~cs_sync_r[SYNC_STAGES-2] & cs_sync_r[SYNC_STAGES-1];
  assign cs_high_s   = cs_sync_r[SYNC_STAGES-2];
  assign mosi_s      = mosi_sync_r[SYNC_STAGES-2];

  // Frame sequencer, shift registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      bit_cnt_r    <= 3'd0;
      rx_r         <= 8'h00;
      tx_r         <= 8'h00;
      rw_r         <= 1'b0;
      addr_r       <= 6'h00;
      data_write_r <= 8'h00;
      read_r       <= 1'b0;
      write_r      <= 1'b0;
      miso_r       <= 1'b0;
    end else begin
      read_r  <= 1'b0;
      write_r <= 1'b0;
      if (cs_high_s) begin
        state_r   <= IDLE;
        bit_cnt_r <= 3'd0;
        miso_r    <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            miso_r <= 1'b0;
            if (cs_fall_s) begin
              state_r   <= CMD;
              bit_cnt_r <= 3'd0;
              rx_r      <= 8'h00;
            end
          end
          CMD: begin
            if (sclk_rise_s) begin
              rx_r      <= {rx_r[6:0], mosi_s};
              bit_cnt_r <= bit_cnt_r + 3'd1;
              if (bit_cnt_r == 3'd7) begin
                // rx_r[6] is the rw bit; rx_r[5] is the ignored bit6.
                addr_r <= {rx_r[4:0], mosi_s};
                rw_r   <= rx_r[6];
                if (rx_r[6]) begin
                  state_r <= DATA;
                end else begin
                  state_r <= RD_REQ;
                  read_r  <= 1'b1;
                end
              end
            end
          end
          RD_REQ: begin
            state_r <= RD_LOAD;
          end
          RD_LOAD: begin
            tx_r    <= bus.data_read;
            miso_r  <= bus.data_read[7];
            state_r <= DATA;
          end
          DATA: begin
            if (sclk_rise_s) begin
              rx_r      <= {rx_r[6:0], mosi_s};
              bit_cnt_r <= bit_cnt_r + 3'd1;
              if (bit_cnt_r == 3'd7) begin
                state_r <= DONE;
                miso_r  <= 1'b0;
                if (rw_r) begin
                  data_write_r <= {rx_r[6:0], mosi_s};
                  write_r      <= 1'b1;
                end
              end
            end else if (sclk_fall_s && !rw_r && (bit_cnt_r != 3'd0)) begin
              // bit_cnt_r==0 here is the fall after the last command bit.
              tx_r   <= {tx_r[6:0], 1'b0};
              miso_r <= tx_r[6];
            end
          end
          DONE: begin
            miso_r <= 1'b0;
          end
          default: begin
            state_r   <= IDLE;
            bit_cnt_r <= 3'd0;
            miso_r    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.miso       = miso_r;
  assign bus.read       = read_r;
  assign bus.write      = write_r;
  assign bus.addr       = addr_r;
  assign bus.data_write = data_write_r;

endmodule

// File: doc/spi_reg_bridge.md
Name: spi_reg_bridge

Overview:
SPI slave front-end that turns 2-byte serial transactions into the single-cycle read/write strobes consumed by the byte-addressable PWM register file. Sits between the chip pins (sclk, cs_n, mosi, miso) and the register file's decoder-facing port. The register file answers read with data_read registered one clk later. All SPI inputs are oversampled in the clk domain; no logic is clocked by sclk.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the input synchronizers on sclk, cs_n, mosi (min 2)

Ports:
clk  input  1  peripheral clock
rst_n  input  1  asynchronous, active-low reset
sclk  input  1  SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous to clk
cs_n  input  1  SPI chip select, active low, asynchronous
mosi  input  1  SPI data in, MSB first
miso  output  1  SPI data out, MSB first, registered
read  output  1  one-clk read strobe to register file
write  output  1  one-clk write strobe to register file
addr  output  6  register address, held from command byte until next command
data_write  output  8  write data, valid with write
data_read  input  8  register file read data, valid 1 clk after read

Behaviour:
- Reset: read=0, write=0, addr=0, data_write=0, miso=0, state=IDLE, bit counter=0, shift registers=0.
- sclk, cs_n, mosi each pass through SYNC_STAGES flops. Rise/fall detected from the last two sync stages. mosi uses the same depth so it aligns with sclk.
- Frame: byte 0 = command, bit7 = 1 for write / 0 for read, bit6 ignored, bits5:0 = addr. Byte 1 = data: mosi for a write, miso for a read.
- mosi is sampled on detected sclk rise. Shift register fills MSB first, 3-bit counter.
- States:
  - IDLE: cs_n high. Synchronized cs_n low -> CMD, counter=0.
  - CMD: 8th rise -> latch addr and the rw flag. Write -> DATA. Read -> RD_REQ.
  - RD_REQ: read=1 for exactly one clk -> RD_LOAD.
  - RD_LOAD: next clk, load data_read into tx shift register; miso = bit7 from the following clk -> DATA.
  - DATA: 8 rises.
    - Write: on the 8th rise, data_write=byte and write=1 for exactly one clk.
    - Read: tx shifts on each detected fall that follows data rises 1..7. The fall after the final command bit does not shift.
    - After the 8th rise -> DONE.
  - DONE: extra sclk edges are ignored. miso=0, no strobes.
- Synchronized cs_n rising in any state -> IDLE, counter cleared, miso=0, same or next clk.
- Abort: cs_n high before the 8th data rise means no write strobe. A read strobe already issued is not retracted.
- miso=0 whenever not in RD_LOAD/DATA of a read.
- read and write are never asserted in the same clk. Each transaction produces at most one strobe.
- addr stays stable after the strobe until the next command completes. data_write stays stable until the next write.
- Timing requirement on the master: sclk high and low times ≥ SYNC_STAGES+3 clk. cs_n low to first sclk rise ≥ SYNC_STAGES+2 clk. This guarantees RD_REQ/RD_LOAD finish before the first data fall. Violations are undefined; the bench does not test them.
- Async reset mid-transaction: all outputs return to reset values immediately. The frame is discarded. The bridge restarts only after a cs_n high->low.

Test Plan:
- Write addr 0x00 data 0xA5 (mosi bytes 0x80, 0xA5) -> exactly one write pulse, addr=0x00, data_write=0xA5, read never asserted.
- Read addr 0x0D with the model returning 0x3C one clk after read (mosi 0x0D, 0x00) -> one read pulse with addr=0x0D; miso sampled on the 8 data rises = 0,0,1,1,1,1,0,0.
- Write 0x8A, 0xFF with cs_n raised after 12 clocks -> no write pulse. Next full write 0x8B, 0x01 -> write addr=0x0B data=0x01.
- Back-to-back: write 0x83/0x34, then read 0x03 returning 0x34 -> miso byte 0x34. Exactly one write then one read strobe.
- 20 sclk cycles in one frame (write 0x8C, 0x01, then 4 extra) -> single write addr 0x0C data 0x01, no further strobes.
- Assert rst_n low after 5 command bits -> outputs zero at once. Release and run a full read of 0x08 -> correct single read and miso data.
